alu_operand_regfile: RTL

//  Operand register file feeding the 8-bit ALU and absorbing its result.

---
 rtl/alu_operand_regfile.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_operand_regfile.sv
// -----------------------------------------------------------------------------
// alu_operand_regfile
//
// Operand register file sitting between the register array and the 8-bit ALU.
// Two combinational read ports supply ALU input1/input2. The ALU result
// (Output/Zero) comes back as a writeback that is first captured into a
// one-entry pending stage and committed into the array on the following edge.
// While the pending stage is valid its value is forwarded to both readers, so
// a captured result is visible immediately after its capture edge.
//
// Ports
//   CLK        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   raddr_a    in   [AW-1:0] read address, operand A (ALU input1)
//   raddr_b    in   [AW-1:0] read address, operand B (ALU input2)
//   rdata_a    out  [DW-1:0] operand A data, combinational
//   rdata_b    out  [DW-1:0] operand B data, combinational
//   wb_en      in   capture wb_data into the pending stage this edge
//   wb_addr    in   [AW-1:0] writeback destination register
//   wb_data    in   [DW-1:0] ALU Output
//   wb_zero    in   ALU Zero
//   flag_en    in   capture wb_zero into zero_flag this edge
//   stall      in   blocks capture of wb_* and flag; commit still proceeds
//   zero_flag  out  registered Zero flag for branch logic
//   pend_valid out  pending writeback not yet committed
// -----------------------------------------------------------------------------
module alu_operand_regfile #(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          wb_zero,
  input  logic          flag_en,
  input  logic          stall,
  output logic          zero_flag,
  output logic          pend_valid
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q,  pend_addr_d;
  logic [DW-1:0] pend_data_q,  pend_data_d;
  logic          zero_flag_q,  zero_flag_d;

  logic capture;
  assign capture = wb_en && !stall;

  // Next-state logic. Commit uses the *current* pending entry, so a capture to
  // the same address on the same edge lands in the pending stage while the
  // array receives the older value.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    regs_d       = regs_q;
    pend_valid_d = capture;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    zero_flag_d  = zero_flag_q;

    if (pend_valid_q) begin
      regs_d[pend_addr_q] = pend_data_q;
    end

    // wb_addr/wb_data are only sampled on a real capture, keeping X's on an
    // idle or stalled bus out of the pending stage.
    if (capture) begin
      pend_addr_d = wb_addr;
      pend_data_d = wb_data;
    end

    if (flag_en && !stall) begin
      zero_flag_d = wb_zero;
    end
  end

  // NOTE: the array is reset along with the control state because a reset
  // must leave every register reading as zero, not merely invalidate entries.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      zero_flag_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      zero_flag_q  <= zero_flag_d;
    end
  end

  // Reads depend only on registered state, never on same-cycle wb_data, which
  // keeps the regfile -> ALU -> regfile path free of combinational loops.
  assign rdata_a = (pend_valid_q && (pend_addr_q == raddr_a)) ? pend_data_q : regs_q[raddr_a];
  assign rdata_b = (pend_valid_q && (pend_addr_q == raddr_b)) ? pend_data_q : regs_q[raddr_b];

  assign zero_flag  = zero_flag_q;
  assign pend_valid = pend_valid_q;

endmodule
